// File: rtl/fetch_stage_pkg.sv
// Shared constants, field positions and the IF/ID payload type for the MIPS32 fetch stage.
package fetch_stage_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR        = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_INC           = 32'd4;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int JIDX_HI = 25;
  localparam int JIDX_LO = 0;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pcPlus4;
    logic            valid;
  } fdRegT;

  localparam fdRegT FD_BUBBLE = '{instr: NOP_INSTR, pcPlus4: '0, valid: 1'b0};

  // J-type target: upper nibble of the delay-slot PC, word index from the instruction.
  function automatic logic [PC_W-1:0] jumpTarget(input logic [PC_W-1:0] pcPlus4,
                                                 input logic [31:0]     instr);
    return {pcPlus4[31:28], instr[JIDX_HI:JIDX_LO], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg_fd.sv
// IF/ID pipeline register: enable holds all fields, clear inserts a bubble.
module pipe_reg_fd
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rstN,
  input  logic  en,
  input  logic  clear,
  input  fdRegT d,
  output fdRegT q
);

  fdRegT fdReg;

  // Hold outranks clear so a stalled branch in decode survives a spurious flush.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      fdReg <= FD_BUBBLE;
    end else if (en) begin
      if (clear) fdReg <= FD_BUBBLE;
      else       fdReg <= d;
    end
  end

  assign q = fdReg;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            pcSrcD,
  input  logic [PC_W-1:0] pcBranchD,
  input  logic            jump,
  input  logic            clearD,
  output logic [PC_W-1:0] imemAddr,
  input  logic [31:0]     imemData,
  input  logic            imemReady,
  output logic [PC_W-1:0] pcF,
  output logic [31:0]     instrD,
  output logic [PC_W-1:0] pcPlus4D,
  output logic [5:0]      opCodeD,
  output logic [5:0]      funcD,
  output logic            validD
);

  logic [PC_W-1:0] pcReg;
  logic [PC_W-1:0] pcNext;
  logic [PC_W-1:0] pcPlus4F;
  fdRegT           fdNext;
  fdRegT           fdQ;

  assign pcPlus4F = pcReg + PC_INC;

  // Redirects beat a fetch miss: the PC moves to the target even if this fetch stalled.
  always_comb begin
    pcNext = pcPlus4F;
    if (stallF)          pcNext = pcReg;
    else if (jump)       pcNext = jumpTarget(fdQ.pcPlus4, fdQ.instr);
    else if (pcSrcD)     pcNext = {pcBranchD[PC_W-1:2], 2'b00};
    else if (!imemReady) pcNext = pcReg;
  end

  always_ff @(posedge clk) begin
    if (!rstN) pcReg <= RESET_PC;
    else       pcReg <= pcNext;
  end

  assign fdNext = '{instr: imemData, pcPlus4: pcPlus4F, valid: 1'b1};

  pipe_reg_fd uFd (
    .clk   (clk),
    .rstN  (rstN),
    .en    (~stallD),
    .clear (clearD | ~imemReady),
    .d     (fdNext),
    .q     (fdQ)
  );

  assign imemAddr = pcReg;
  assign pcF      = pcReg;
  assign instrD   = fdQ.instr;
  assign pcPlus4D = fdQ.pcPlus4;
  assign validD   = fdQ.valid;
  assign opCodeD  = fdQ.instr[OP_HI:OP_LO];
  assign funcD    = fdQ.instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized hazards vs. a rule-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stallF, stallD, pcSrcD, jump, clearD, imemReady;
  logic [31:0] pcBranchD;
  logic [31:0] imemAddr, imemData, pcF, instrD, pcPlus4D;
  logic [5:0]  opCodeD, funcD;
  logic        validD;

  int checks = 0;
  int errors = 0;

  // Model state: what the fetch stage should hold after each edge.
  logic [31:0] mPc, mInstr, mPp4;
  logic        mValid;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk       (clk),
    .rstN      (rstN),
    .stallF    (stallF),
    .stallD    (stallD),
    .pcSrcD    (pcSrcD),
    .pcBranchD (pcBranchD),
    .jump      (jump),
    .clearD    (clearD),
    .imemAddr  (imemAddr),
    .imemData  (imemData),
    .imemReady (imemReady),
    .pcF       (pcF),
    .instrD    (instrD),
    .pcPlus4D  (pcPlus4D),
    .opCodeD   (opCodeD),
    .funcD     (funcD),
    .validD    (validD)
  );

  // Instruction memory contents: a hash of the address, with one planted jump word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h1000_000C) return 32'h0800_0040;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imemData = memWord(imemAddr);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelEdge();
    logic [31:0] seqPc;
    logic [31:0] nextPc;
    if (!rstN) begin
      mPc = 32'h0; mInstr = 32'h0; mPp4 = 32'h0; mValid = 1'b0;
    end else begin
      seqPc  = mPc + 32'd4;
      nextPc = seqPc;
      if (stallF)          nextPc = mPc;
      else if (jump)       nextPc = {mPp4[31:28], mInstr[25:0], 2'b00};
      else if (pcSrcD)     nextPc = {pcBranchD[31:2], 2'b00};
      else if (!imemReady) nextPc = mPc;
      if (!stallD) begin
        if (clearD || !imemReady) begin
          mInstr = 32'h0; mPp4 = 32'h0; mValid = 1'b0;
        end else begin
          mInstr = memWord(mPc); mPp4 = seqPc; mValid = 1'b1;
        end
      end
      mPc = nextPc;
    end
  endtask

  // One transaction: drive inputs, clock once, compare every output with the model.
  task automatic cycle(input logic rst, input logic sF, input logic sD, input logic br,
                       input logic jp, input logic clr, input logic rdy, input logic [31:0] bt);
    rstN = rst; stallF = sF; stallD = sD; pcSrcD = br; jump = jp; clearD = clr;
    imemReady = rdy; pcBranchD = bt;
    @(posedge clk);
    modelEdge();
    #1;
    checkVal("pcF", pcF, mPc);
    checkVal("imemAddr", imemAddr, mPc);
    checkVal("instrD", instrD, mInstr);
    checkVal("pcPlus4D", pcPlus4D, mPp4);
    checkVal("opCodeD", {26'h0, opCodeD}, {26'h0, mInstr[31:26]});
    checkVal("funcD", {26'h0, funcD}, {26'h0, mInstr[5:0]});
    checkVal("validD", {31'h0, validD}, {31'h0, mValid});
    $display("cyc rst=%b sF=%b sD=%b br=%b j=%b clr=%b rdy=%b pcF=%h instrD=%h v=%b",
             rst, sF, sD, br, jp, clr, rdy, pcF, instrD, validD);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic branchTo(input logic [31:0] t);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, t);
  endtask

  initial begin
    logic [31:0] holdPc, holdInstr, holdPp4;
    logic        holdValid;
    mPc = 32'h0; mInstr = 32'h0; mPp4 = 32'h0; mValid = 1'b0;

    // Reset state.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkVal("rst_pcF", pcF, 32'h0);
    checkVal("rst_valid", {31'h0, validD}, 32'h0);
    checkVal("rst_instr", instrD, 32'h0);

    // Sequential fetch.
    for (int k = 1; k <= 4; k++) begin
      idle();
      checkVal("seq_pcF", pcF, 32'(4 * k));
      checkVal("seq_instr", instrD, memWord(32'(4 * (k - 1))));
      checkVal("seq_valid", {31'h0, validD}, 32'h1);
    end

    // Taken branch with unaligned target.
    branchTo(32'h0000_0103);
    checkVal("br_pcF", pcF, 32'h0000_0100);
    checkVal("br_bubble", {31'h0, validD}, 32'h0);
    idle();
    checkVal("br_target_instr", instrD, memWord(32'h0000_0100));
    checkVal("br_next_pcF", pcF, 32'h0000_0104);

    // Jump wins over a simultaneous branch.
    branchTo(32'h1000_000C);
    idle();
    checkVal("j_setup_instr", instrD, 32'h0800_0040);
    checkVal("j_setup_pp4", pcPlus4D, 32'h1000_0010);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500);
    checkVal("jump_pcF", pcF, 32'h1000_0100);

    // Stall beats clear and redirect.
    idle();
    holdPc = pcF; holdInstr = instrD; holdPp4 = pcPlus4D; holdValid = validD;
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0800);
    checkVal("stall_pcF", pcF, holdPc);
    checkVal("stall_instr", instrD, holdInstr);
    checkVal("stall_pp4", pcPlus4D, holdPp4);
    checkVal("stall_valid", {31'h0, validD}, {31'h0, holdValid});

    // Fetch miss for three cycles at 0x20.
    branchTo(32'h0000_0020);
    repeat (3) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkVal("miss_pcF", pcF, 32'h0000_0020);
      checkVal("miss_valid", {31'h0, validD}, 32'h0);
    end
    idle();
    checkVal("miss_done_instr", instrD, memWord(32'h0000_0020));
    checkVal("miss_done_pcF", pcF, 32'h0000_0024);

    // PC wrap.
    branchTo(32'hFFFF_FFFC);
    idle();
    checkVal("wrap_pcF", pcF, 32'h0);
    checkVal("wrap_pp4", pcPlus4D, 32'h0);

    // Reset overrides stall, jump and a fetch miss.
    idle();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkVal("rst_mid_pcF", pcF, 32'h0);
    checkVal("rst_mid_valid", {31'h0, validD}, 32'h0);

    // Randomized hazards and memory readiness.
    for (int n = 0; n < 400; n++) begin
      logic r, sF, sD, br, jp, clr, rdy;
      r   = ($urandom_range(63) != 0);
      sF  = ($urandom_range(5) == 0);
      sD  = sF ? ($urandom_range(3) != 0) : ($urandom_range(9) == 0);
      br  = ($urandom_range(7) == 0);
      jp  = ($urandom_range(9) == 0);
      clr = (br | jp) ? ($urandom_range(7) != 0) : ($urandom_range(15) == 0);
      rdy = ($urandom_range(4) != 0);
      cycle(r, sF, sD, br, jp, clr, rdy, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
